fdc_dco_gen: RTL and testbench
==============================

Name: fdc_dco_gen

Overview:
- Digital-to-frequency generator; the inverse of the FDC measurement path.
- Converts a 5-bit frequency code into a square wave.
- Used as an on-chip stimulus source for the FDC VCO input and for closed-loop self-test: FDC code in, regenerated frequency out.
- Two modes: phase-accumulator NCO (fractional periods) and integer divider.
- New codes are accepted by valid/ready and applied only at a period boundary, so the output never glitches.

Parameters:
- CODE_W, 5: width of the frequency code.
- ACC_W, 16: NCO phase accumulator width. Must satisfy ACC_W >= CODE_W+2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: run request; level-sensitive.
- code, input, CODE_W: requested frequency code.
- selec, input, 1: mode for the offered code (0 = NCO, 1 = divider); travels with code.
- code_valid, input, 1: code/selec offered.
- code_ready, output, 1: pending slot free.
- vco_out, output, 1: generated square wave, registered.
- period_tick, output, 1: one-cycle pulse on each period boundary.
- cur_code, output, CODE_W: code currently in effect.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; cur_code=0; cur_mode=0.
  - pend_v=0; acc=0; cnt=0.
  - vco_out=0; period_tick=0; code_ready=1.
- Handshake:
  - code_ready = ~pend_v.
  - Transfer occurs when code_valid & code_ready: {selec,code} is loaded into the pending register and pend_v<=1.
  - code/selec must be held stable while code_valid=1 and code_ready=0.
- FSM states: IDLE, RUN.
- IDLE:
  - vco_out=0; acc=0; cnt=0.
  - If pend_v=1, apply the pending code (cur<=pend, pend_v<=0) on that cycle.
  - If enable=1, go to RUN next cycle.
- RUN:
  - If enable=0, go to IDLE next cycle; vco_out=0 from that cycle on; no period_tick.
- NCO mode (cur_mode=0):
  - acc <= acc + ((cur_code+1) << (ACC_W-CODE_W-1)), modulo 2^ACC_W.
  - vco_out = acc[ACC_W-1].
  - Mean period = 2^(CODE_W+1)/(cur_code+1) cycles: 64 for code 0, 2 for code 31.
  - Boundary = accumulator carry-out (the cycle in which vco_out falls).
- Divider mode (cur_mode=1):
  - cnt counts 0..cur_code. When cnt==cur_code: cnt<=0 and vco_out toggles.
  - Period = 2*(cur_code+1) cycles, 50% duty, first half low after entering RUN.
  - Boundary = the toggle from 1 to 0.
- period_tick: asserted in the same cycle vco_out goes 1->0 in RUN, registered alongside vco_out.
- Code update at a boundary with pend_v=1:
  - cur<=pend; pend_v<=0; code_ready rises the next cycle.
  - If the mode does not change: acc keeps phase (NCO); cnt restarts at 0 (divider).
  - If the mode changes: acc<=0 and cnt<=0.
- Simultaneous events:
  - Boundary apply and a new transfer in the same cycle cannot occur, because ready=0 while pending. After apply, a transfer is possible the next cycle.
  - enable falling in a boundary cycle: the boundary is still honoured (tick, apply), then go to IDLE.
- Widths: increment computed in ACC_W bits; no saturation; wrap is intentional.

Decomposition:
- Package fdc_pkg holds:
  - CODE_W and ACC_W defaults.
  - typedef dco_mode_e {DCO_NCO, DCO_DIV}.
  - typedef dco_state_e {IDLE, RUN}.
  - localparam INC_SHIFT = ACC_W-CODE_W-1.
- Sub-module fdc_dco_core: acc/cnt datapath, vco_out and boundary generation, driven by cur_code, cur_mode and run.
- Top level: FSM, pending register and handshake.

Test Plan:
- Divider, code=3, enable=1 -> vco_out 4 cycles low, 4 high, period 8; period_tick every 8 cycles at each 1->0 edge; cur_code=3.
- NCO, code=31 -> vco_out toggles every cycle; tick every 2 cycles. NCO code=0 -> 32 low, 32 high, period 64.
- Back-pressure: offer code 7, then code 15 immediately while running NCO code 0 -> second offer sees code_ready=0 until the first boundary after the first applies; each code takes effect only at successive boundaries; no output pulse shorter than the old or new half-period.
- Mode switch: NCO code 1 -> divider code 1 at a boundary -> acc/cnt cleared; next period exactly 4 cycles (2 low, 2 high).
- enable dropped mid-high-phase -> vco_out=0 the following cycle and no tick; re-enable -> restart from acc=0 (NCO code 3: first rise after 8 cycles).
- Async reset asserted mid-RUN between clock edges -> all outputs 0 and code_ready=1 immediately; pending code discarded; cur_code=0.

Source files
------------

// File: rtl/fdc_pkg.sv
// rtl/fdc_pkg.sv - shared types and default widths for the DCO frequency generator
package fdc_pkg;

    localparam int CODE_W    = 5;
    localparam int ACC_W     = 16;
    localparam int INC_SHIFT = ACC_W - CODE_W - 1;

    typedef enum logic {
        DCO_NCO = 1'b0,
        DCO_DIV = 1'b1
    } dco_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dco_state_e;

endpackage

// File: rtl/fdc_dco_core.sv
// rtl/fdc_dco_core.sv - phase accumulator / divider datapath producing vco_out and period boundaries
module fdc_dco_core #(
    parameter int CODE_W = fdc_pkg::CODE_W,
    parameter int ACC_W  = fdc_pkg::ACC_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic              stop_i,
    input  logic              restart_i,
    input  logic [CODE_W-1:0] cur_code_i,
    input  fdc_pkg::dco_mode_e cur_mode_i,
    output logic              boundary_o,
    output logic              vco_out_o,
    output logic              period_tick_o
);
    import fdc_pkg::*;

    localparam int INC_SHIFT = ACC_W - CODE_W - 1;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CODE_W-1:0] cnt_q, cnt_d;
    logic              vco_q, vco_d;
    logic              tick_q, tick_d;

    logic [ACC_W-1:0]  code_ext;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W:0]    sum;
    logic              cnt_wrap;

    assign code_ext = {{(ACC_W-CODE_W){1'b0}}, cur_code_i};
    assign inc      = (code_ext + ACC_W'(1)) << INC_SHIFT;
    assign sum      = {1'b0, acc_q} + {1'b0, inc};
    assign cnt_wrap = (cnt_q == cur_code_i);

    // The increment never exceeds half scale, so a carry always coincides with the MSB falling.
    assign boundary_o = run_i & ((cur_mode_i == DCO_NCO) ? sum[ACC_W] : (cnt_wrap & vco_q));

    always_comb begin
        acc_d  = '0;
        cnt_d  = '0;
        vco_d  = 1'b0;
        tick_d = boundary_o;
        if (run_i && !stop_i && !restart_i) begin
            if (cur_mode_i == DCO_NCO) begin
                acc_d = sum[ACC_W-1:0];
                vco_d = sum[ACC_W-1];
            end else begin
                cnt_d = cnt_wrap ? '0 : cnt_q + CODE_W'(1);
                vco_d = cnt_wrap ? ~vco_q : vco_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            vco_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            vco_q  <= vco_d;
            tick_q <= tick_d;
        end
    end

    assign vco_out_o     = vco_q;
    assign period_tick_o = tick_q;

endmodule

// File: rtl/fdc_dco_gen.sv
// rtl/fdc_dco_gen.sv - code-to-frequency generator: run FSM, pending code slot and handshake
module fdc_dco_gen #(
    parameter int CODE_W = fdc_pkg::CODE_W,
    parameter int ACC_W  = fdc_pkg::ACC_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              selec_i,
    input  logic              code_valid_i,
    output logic              code_ready_o,
    output logic              vco_out_o,
    output logic              period_tick_o,
    output logic [CODE_W-1:0] cur_code_o
);
    import fdc_pkg::*;

    dco_state_e        state_q;
    logic [CODE_W-1:0] cur_code_q;
    dco_mode_e         cur_mode_q;
    logic [CODE_W-1:0] pend_code_q;
    dco_mode_e         pend_mode_q;
    logic              pend_v_q;
    logic              code_ready_q;

    logic run, stop, boundary, apply, restart, xfer;

    assign run     = (state_q == RUN);
    assign stop    = ~enable_i;
    assign xfer    = code_valid_i & ~pend_v_q;
    // Codes only switch at a falling edge of vco_out (or while idle), so no short pulse is emitted.
    assign apply   = pend_v_q & (~run | boundary);
    assign restart = apply & run & (pend_mode_q != cur_mode_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cur_code_q   <= '0;
            cur_mode_q   <= DCO_NCO;
            pend_code_q  <= '0;
            pend_mode_q  <= DCO_NCO;
            pend_v_q     <= 1'b0;
            code_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE:    if (enable_i)  state_q <= RUN;
                RUN:     if (!enable_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (apply) begin
                cur_code_q   <= pend_code_q;
                cur_mode_q   <= pend_mode_q;
                pend_v_q     <= 1'b0;
                code_ready_q <= 1'b1;
            end else if (xfer) begin
                pend_code_q  <= code_i;
                pend_mode_q  <= dco_mode_e'(selec_i);
                pend_v_q     <= 1'b1;
                code_ready_q <= 1'b0;
            end
        end
    end

    fdc_dco_core #(
        .CODE_W (CODE_W),
        .ACC_W  (ACC_W)
    ) u_core (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .run_i         (run),
        .stop_i        (stop),
        .restart_i     (restart),
        .cur_code_i    (cur_code_q),
        .cur_mode_i    (cur_mode_q),
        .boundary_o    (boundary),
        .vco_out_o     (vco_out_o),
        .period_tick_o (period_tick_o)
    );

    assign code_ready_o = code_ready_q;
    assign cur_code_o   = cur_code_q;

endmodule

// File: tb/tb_fdc_dco_gen.sv
// tb/tb_fdc_dco_gen.sv - directed self-checking bench for fdc_dco_gen
module tb_fdc_dco_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] code;
    logic       selec;
    logic       code_valid;
    logic       code_ready;
    logic       vco_out;
    logic       period_tick;
    logic [4:0] cur_code;

    int n_chk = 0;
    int n_err = 0;

    logic vtr [0:255];
    logic ttr [0:255];
    int first_hi, first_tk, n_hi, n_tk, min_gap, max_gap, n_bad, min_run;
    int w;

    always #5 clk = ~clk;

    fdc_dco_gen dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (enable),
        .code_i        (code),
        .selec_i       (selec),
        .code_valid_i  (code_valid),
        .code_ready_o  (code_ready),
        .vco_out_o     (vco_out),
        .period_tick_o (period_tick),
        .cur_code_o    (cur_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trace(input int n);
        int last, start, len;
        for (int i = 0; i < n; i++) begin
            step();
            vtr[i] = vco_out;
            ttr[i] = period_tick;
        end
        first_hi = -1; first_tk = -1; n_hi = 0; n_tk = 0;
        min_gap = 9999; max_gap = 0; n_bad = 0; min_run = 9999;
        last = -1; start = 0;
        for (int i = 0; i < n; i++) begin
            if (vtr[i]) begin
                n_hi++;
                if (first_hi < 0) first_hi = i;
            end
            if (ttr[i]) begin
                n_tk++;
                if (first_tk < 0) first_tk = i;
                if (vtr[i] || (i > 0 && !vtr[i-1])) n_bad++;
                if (last >= 0) begin
                    if (i - last < min_gap) min_gap = i - last;
                    if (i - last > max_gap) max_gap = i - last;
                end
                last = i;
            end
        end
        for (int i = 1; i <= n; i++) begin
            if (i == n || vtr[i] != vtr[i-1]) begin
                len = i - start;
                if (start > 0 && i < n && len < min_run) min_run = len;
                start = i;
            end
        end
    endtask

    task automatic send_code(input logic [4:0] c, input logic m, output int waits);
        code = c;
        selec = m;
        code_valid = 1'b1;
        waits = 0;
        while (!code_ready && waits < 300) begin
            step();
            waits++;
        end
        if (!code_ready) chk("send_timeout", 32'(code_ready), 1);
        step();
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        code_valid = 1'b0;
        code = '0;
        selec = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        step();
    endtask

    task automatic start(input logic [4:0] c, input logic m);
        int ww;
        do_reset();
        send_code(c, m, ww);
        step();
        chk("start_cur_code", 32'(cur_code), 32'(c));
        chk("start_ready", 32'(code_ready), 1);
        enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; code_valid = 1'b0; code = '0; selec = 1'b0;
        #12;
        chk("rst_vco", 32'(vco_out), 0);
        chk("rst_tick", 32'(period_tick), 0);
        chk("rst_ready", 32'(code_ready), 1);
        chk("rst_cur", 32'(cur_code), 0);

        // Divider code 3: 4 low, 4 high
        start(5'd3, 1'b1);
        trace(40);
        chk("div3_first_hi", first_hi, 4);
        chk("div3_first_tk", first_tk, 8);
        chk("div3_n_tk", n_tk, 4);
        chk("div3_min_gap", min_gap, 8);
        chk("div3_max_gap", max_gap, 8);
        chk("div3_n_hi", n_hi, 20);
        chk("div3_bad_tick", n_bad, 0);

        // NCO code 31: toggle each cycle
        start(5'd31, 1'b0);
        trace(40);
        chk("nco31_first_hi", first_hi, 1);
        chk("nco31_first_tk", first_tk, 2);
        chk("nco31_n_tk", n_tk, 19);
        chk("nco31_min_gap", min_gap, 2);
        chk("nco31_max_gap", max_gap, 2);
        chk("nco31_n_hi", n_hi, 20);

        // NCO code 0: period 64
        start(5'd0, 1'b0);
        trace(140);
        chk("nco0_first_hi", first_hi, 32);
        chk("nco0_first_tk", first_tk, 64);
        chk("nco0_n_tk", n_tk, 2);
        chk("nco0_gap", min_gap, 64);
        chk("nco0_n_hi", n_hi, 64);
        chk("nco0_bad_tick", n_bad, 0);

        // Back-pressure: 7 then 15 while running NCO code 0
        start(5'd0, 1'b0);
        trace(10);
        send_code(5'd7, 1'b0, w);
        chk("bp_first_wait", w, 0);
        send_code(5'd15, 1'b0, w);
        chk("bp_second_wait", w, 54);
        chk("bp_cur7", 32'(cur_code), 7);
        chk("bp_ready_low", 32'(code_ready), 0);
        trace(16);
        chk("bp_first_hi", first_hi, 2);
        chk("bp_first_tk", first_tk, 6);
        chk("bp_n_tk", n_tk, 3);
        chk("bp_min_gap", min_gap, 4);
        chk("bp_max_gap", max_gap, 4);
        chk("bp_min_run", min_run, 2);
        chk("bp_n_hi", n_hi, 8);
        chk("bp_cur15", 32'(cur_code), 15);

        // Mode switch NCO 1 -> divider 1
        start(5'd1, 1'b0);
        trace(2);
        send_code(5'd1, 1'b1, w);
        chk("ms_wait", w, 0);
        trace(40);
        chk("ms_first_hi", first_hi, 13);
        chk("ms_first_tk", first_tk, 29);
        chk("ms_n_tk", n_tk, 3);
        chk("ms_min_gap", min_gap, 4);
        chk("ms_max_gap", max_gap, 4);
        chk("ms_low_after", 32'(vtr[30]), 0);
        chk("ms_high_after", 32'(vtr[31]), 1);
        chk("ms_n_hi", n_hi, 21);
        chk("ms_bad_tick", n_bad, 0);

        // Enable drop mid-high, then restart from acc=0
        start(5'd3, 1'b0);
        trace(11);
        chk("en_mid_high", 32'(vtr[10]), 1);
        enable = 1'b0;
        trace(4);
        chk("en_off_hi", n_hi, 0);
        chk("en_off_tk", n_tk, 0);
        enable = 1'b1;
        trace(20);
        chk("en_re_first_hi", first_hi, 8);
        chk("en_re_first_tk", first_tk, 16);
        chk("en_re_n_hi", n_hi, 8);

        // Enable falling on a boundary cycle still ticks and applies
        start(5'd31, 1'b0);
        trace(1);
        send_code(5'd5, 1'b0, w);
        chk("eb_hi", 32'(vco_out), 1);
        enable = 1'b0;
        step();
        chk("eb_tick", 32'(period_tick), 1);
        chk("eb_cur", 32'(cur_code), 5);
        chk("eb_vco", 32'(vco_out), 0);
        step();
        chk("eb_tick_after", 32'(period_tick), 0);

        // Async reset mid-RUN with a pending code
        start(5'd0, 1'b0);
        trace(40);
        send_code(5'd9, 1'b0, w);
        chk("ar_pre_vco", 32'(vco_out), 1);
        chk("ar_pre_ready", 32'(code_ready), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_vco", 32'(vco_out), 0);
        chk("ar_tick", 32'(period_tick), 0);
        chk("ar_ready", 32'(code_ready), 1);
        chk("ar_cur", 32'(cur_code), 0);
        enable = 1'b0;
        #2;
        reset = 1'b0;
        repeat (3) step();
        chk("ar_pend_dropped", 32'(cur_code), 0);
        chk("ar_post_vco", 32'(vco_out), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
